// File: rtl/cache_bus_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : cache_bus_arbiter
//  Description : Round-robin arbiter that shares one cache refill/writeback
//                burst bus between PORT_NUM cache ports. The grant is held
//                for a whole burst (address, W beats, R beats, B response).
//  Revision    : 1.0  initial release
// ============================================================================
module cache_bus_arbiter #(
    parameter int PORT_NUM = 2,
    parameter int LEN_W    = 8
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [PORT_NUM-1:0]       s_req_valid,
    output logic [PORT_NUM-1:0]       s_req_ready,
    input  logic [PORT_NUM-1:0]       s_req_write,
    input  logic [PORT_NUM*32-1:0]    s_req_addr,
    input  logic [PORT_NUM*LEN_W-1:0] s_req_len,
    input  logic [PORT_NUM-1:0]       s_w_valid,
    input  logic [PORT_NUM*32-1:0]    s_w_data,
    input  logic [PORT_NUM*4-1:0]     s_w_strb,
    input  logic [PORT_NUM-1:0]       s_w_last,
    output logic [PORT_NUM-1:0]       s_w_ready,
    output logic [PORT_NUM-1:0]       s_r_valid,
    output logic [31:0]               s_r_data,
    output logic                      s_r_last,
    input  logic [PORT_NUM-1:0]       s_r_ready,
    output logic [PORT_NUM-1:0]       s_b_valid,
    output logic                      m_req_valid,
    input  logic                      m_req_ready,
    output logic                      m_req_write,
    output logic [31:0]               m_req_addr,
    output logic [LEN_W-1:0]          m_req_len,
    output logic                      m_w_valid,
    output logic [31:0]               m_w_data,
    output logic [3:0]                m_w_strb,
    output logic                      m_w_last,
    input  logic                      m_w_ready,
    input  logic                      m_r_valid,
    input  logic [31:0]               m_r_data,
    input  logic                      m_r_last,
    output logic                      m_r_ready,
    input  logic                      m_b_valid,
    output logic                      m_b_ready
);

    localparam int                  IDX_W      = (PORT_NUM > 1) ? $clog2(PORT_NUM) : 1;
    localparam logic [IDX_W-1:0]    c_rr_reset = IDX_W'(PORT_NUM - 1);
    localparam logic [PORT_NUM-1:0] c_one_hot0 = PORT_NUM'(1);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_ADDR  = 3'd1,
        S_RDATA = 3'd2,
        S_WDATA = 3'd3,
        S_WRESP = 3'd4
    } state_t;

    state_t                r_state;
    state_t                w_state_nxt;
    logic [PORT_NUM-1:0]   r_grant;
    logic [PORT_NUM-1:0]   w_grant_nxt;
    logic [IDX_W-1:0]      r_gidx;
    logic [IDX_W-1:0]      w_gidx_nxt;
    logic [IDX_W-1:0]      r_rr_ptr;
    logic [IDX_W-1:0]      w_rr_ptr_nxt;

    logic                  w_pick_found;
    logic [IDX_W-1:0]      w_pick_idx;
    int                    w_pick_best;

    logic                  w_g_req_write;
    logic [31:0]           w_g_req_addr;
    logic [LEN_W-1:0]      w_g_req_len;
    logic                  w_g_w_valid;
    logic [31:0]           w_g_w_data;
    logic [3:0]            w_g_w_strb;
    logic                  w_g_w_last;
    logic                  w_g_r_ready;

    // Round-robin pick: smallest circular distance after the last winner wins.
    always_comb begin
        w_pick_found = 1'b0;
        w_pick_idx   = '0;
        w_pick_best  = PORT_NUM;
        for (int j = 0; j < PORT_NUM; j++) begin
            if (s_req_valid[j] &&
                (((j > int'(r_rr_ptr)) ? (j - int'(r_rr_ptr) - 1)
                                       : (j + PORT_NUM - int'(r_rr_ptr) - 1)) < w_pick_best)) begin
                w_pick_best  = (j > int'(r_rr_ptr)) ? (j - int'(r_rr_ptr) - 1)
                                                    : (j + PORT_NUM - int'(r_rr_ptr) - 1);
                w_pick_idx   = IDX_W'(j);
                w_pick_found = 1'b1;
            end
        end
    end

    // Select the granted port's request, write and read-ready signals.
    always_comb begin
        w_g_req_write = 1'b0;
        w_g_req_addr  = '0;
        w_g_req_len   = '0;
        w_g_w_valid   = 1'b0;
        w_g_w_data    = '0;
        w_g_w_strb    = '0;
        w_g_w_last    = 1'b0;
        w_g_r_ready   = 1'b0;
        for (int j = 0; j < PORT_NUM; j++) begin
            if (r_gidx == IDX_W'(j)) begin
                w_g_req_write = s_req_write[j];
                w_g_req_addr  = s_req_addr[j*32 +: 32];
                w_g_req_len   = s_req_len[j*LEN_W +: LEN_W];
                w_g_w_valid   = s_w_valid[j];
                w_g_w_data    = s_w_data[j*32 +: 32];
                w_g_w_strb    = s_w_strb[j*4 +: 4];
                w_g_w_last    = s_w_last[j];
                w_g_r_ready   = s_r_ready[j];
            end
        end
    end

    // State, grant and round-robin pointer registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= S_IDLE;
            r_grant  <= '0;
            r_gidx   <= '0;
            r_rr_ptr <= c_rr_reset;
        end else begin
            r_state  <= w_state_nxt;
            r_grant  <= w_grant_nxt;
            r_gidx   <= w_gidx_nxt;
            r_rr_ptr <= w_rr_ptr_nxt;
        end
    end

    // Next-state logic and handshake pass-through for the granted port.
    always_comb begin
        w_state_nxt  = r_state;
        w_grant_nxt  = r_grant;
        w_gidx_nxt   = r_gidx;
        w_rr_ptr_nxt = r_rr_ptr;
        s_req_ready  = '0;
        s_w_ready    = '0;
        s_r_valid    = '0;
        s_b_valid    = '0;
        m_req_valid  = 1'b0;
        m_w_valid    = 1'b0;
        m_r_ready    = 1'b0;
        m_b_ready    = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_pick_found) begin
                    w_state_nxt = S_ADDR;
                    w_gidx_nxt  = w_pick_idx;
                    w_grant_nxt = c_one_hot0 << w_pick_idx;
                end
            end
            S_ADDR: begin
                m_req_valid = 1'b1;
                if (m_req_ready) begin
                    s_req_ready = r_grant;
                    w_state_nxt = w_g_req_write ? S_WDATA : S_RDATA;
                end
            end
            S_RDATA: begin
                m_r_ready = w_g_r_ready;
                s_r_valid = m_r_valid ? r_grant : '0;
                if (m_r_valid && w_g_r_ready && m_r_last) begin
                    w_state_nxt  = S_IDLE;
                    w_rr_ptr_nxt = r_gidx;
                    w_grant_nxt  = '0;
                end
            end
            S_WDATA: begin
                m_w_valid = w_g_w_valid;
                s_w_ready = m_w_ready ? r_grant : '0;
                if (w_g_w_valid && m_w_ready && w_g_w_last) begin
                    w_state_nxt = S_WRESP;
                end
            end
            S_WRESP: begin
                m_b_ready = 1'b1;
                s_b_valid = m_b_valid ? r_grant : '0;
                if (m_b_valid) begin
                    w_state_nxt  = S_IDLE;
                    w_rr_ptr_nxt = r_gidx;
                    w_grant_nxt  = '0;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    assign m_req_write = w_g_req_write;
    assign m_req_addr  = w_g_req_addr;
    assign m_req_len   = w_g_req_len;
    assign m_w_data    = w_g_w_data;
    assign m_w_strb    = w_g_w_strb;
    assign m_w_last    = w_g_w_last;
    assign s_r_data    = m_r_data;
    assign s_r_last    = m_r_last;

endmodule
`default_nettype wire

// File: tb/tb_cache_bus_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_cache_bus_arbiter
//  Description : Self-checking bench for cache_bus_arbiter. Cache-port and
//                downstream-slave behaviour is randomised; a transaction-level
//                reference model predicts every handshake output per cycle.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_cache_bus_arbiter;

    localparam int NP = 2;
    localparam int LW = 8;

    logic              clk = 1'b0;
    logic              rst;
    logic [NP-1:0]     s_req_valid, s_req_ready, s_req_write;
    logic [NP*32-1:0]  s_req_addr;
    logic [NP*LW-1:0]  s_req_len;
    logic [NP-1:0]     s_w_valid, s_w_last, s_w_ready;
    logic [NP*32-1:0]  s_w_data;
    logic [NP*4-1:0]   s_w_strb;
    logic [NP-1:0]     s_r_valid, s_r_ready, s_b_valid;
    logic [31:0]       s_r_data;
    logic              s_r_last;
    logic              m_req_valid, m_req_ready, m_req_write;
    logic [31:0]       m_req_addr;
    logic [LW-1:0]     m_req_len;
    logic              m_w_valid, m_w_last, m_w_ready;
    logic [31:0]       m_w_data;
    logic [3:0]        m_w_strb;
    logic              m_r_valid, m_r_last, m_r_ready;
    logic [31:0]       m_r_data;
    logic              m_b_valid, m_b_ready;

    always #5 clk = ~clk;

    cache_bus_arbiter #(.PORT_NUM(NP), .LEN_W(LW)) dut (
        .clk(clk), .rst(rst),
        .s_req_valid(s_req_valid), .s_req_ready(s_req_ready), .s_req_write(s_req_write),
        .s_req_addr(s_req_addr), .s_req_len(s_req_len),
        .s_w_valid(s_w_valid), .s_w_data(s_w_data), .s_w_strb(s_w_strb),
        .s_w_last(s_w_last), .s_w_ready(s_w_ready),
        .s_r_valid(s_r_valid), .s_r_data(s_r_data), .s_r_last(s_r_last),
        .s_r_ready(s_r_ready), .s_b_valid(s_b_valid),
        .m_req_valid(m_req_valid), .m_req_ready(m_req_ready), .m_req_write(m_req_write),
        .m_req_addr(m_req_addr), .m_req_len(m_req_len),
        .m_w_valid(m_w_valid), .m_w_data(m_w_data), .m_w_strb(m_w_strb),
        .m_w_last(m_w_last), .m_w_ready(m_w_ready),
        .m_r_valid(m_r_valid), .m_r_data(m_r_data), .m_r_last(m_r_last), .m_r_ready(m_r_ready),
        .m_b_valid(m_b_valid), .m_b_ready(m_b_ready)
    );

    int checks = 0;
    int errors = 0;

    // cache-port agents: 0 idle, 1 requesting, 2 sending W beats, 3 awaiting end
    int          p_st[NP], p_len[NP], p_beat[NP], p_left[NP], p_gap[NP], p_wait[NP];
    logic [31:0] p_addr[NP];
    logic        p_wr[NP];
    logic        p_force[NP];
    logic [31:0] f_addr[NP];
    int          f_len[NP];
    logic        f_wr[NP];
    int          rx_beats[NP], b_cnt[NP];
    int          gap_max[NP];

    // downstream slave agent
    logic        sl_rd, sl_wr, sl_b;
    logic [31:0] sl_addr;
    int          sl_len, sl_beat, sl_bdelay, sl_req_delay, addr_cnt, sl_wbeats;

    // bench modes
    int          r_mode, rr_phase;
    bit          stray_en, req_slow;

    // reference model: current transaction record and last winner
    bit          mb_busy, mb_addr_done, mb_wr, mb_wdone;
    int          mb_gp, mb_last;
    int          glog[$];

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] wdat(input logic [31:0] a, input int b);
        if (a == 32'h2000) return 32'hA0 + 32'(b);
        return a ^ (32'h0101_0101 * 32'(b + 1)) ^ 32'h5A00_0000;
    endfunction

    function automatic logic [31:0] rdat(input logic [31:0] a, input int b);
        return ~a + 32'(b * 7);
    endfunction

    // round robin: first requester after the last winner, circularly
    function automatic int rr_pick(input logic [NP-1:0] v, input int last);
        for (int k = 1; k <= NP; k++) begin
            if (v[(last + k) % NP]) return (last + k) % NP;
        end
        return -1;
    endfunction

    function automatic bit all_idle();
        bit r;
        r = !mb_busy && !sl_b;
        for (int p = 0; p < NP; p++) if (p_st[p] != 0 || p_left[p] != 0) r = 1'b0;
        return r;
    endfunction

    task automatic reset_agents();
        for (int p = 0; p < NP; p++) begin
            p_st[p] = 0; p_left[p] = 0; p_gap[p] = 0; p_beat[p] = 0;
            p_wait[p] = 0; p_force[p] = 1'b0; p_len[p] = 0; p_addr[p] = '0; p_wr[p] = 1'b0;
        end
        sl_rd = 1'b0; sl_wr = 1'b0; sl_b = 1'b0; sl_beat = 0; addr_cnt = 0;
        sl_req_delay = req_slow ? 5 : 0;
        mb_busy = 1'b0; mb_addr_done = 1'b0; mb_wdone = 1'b0; mb_wr = 1'b0;
        mb_gp = 0; mb_last = NP - 1;
    endtask

    task automatic chk_quiet(input string tag);
        chk({tag, "_m_req_valid"}, m_req_valid, 0);
        chk({tag, "_s_req_ready"}, s_req_ready, 0);
        chk({tag, "_s_w_ready"},   s_w_ready, 0);
        chk({tag, "_s_r_valid"},   s_r_valid, 0);
        chk({tag, "_s_b_valid"},   s_b_valid, 0);
        chk({tag, "_m_w_valid"},   m_w_valid, 0);
        chk({tag, "_m_r_ready"},   m_r_ready, 0);
        chk({tag, "_m_b_ready"},   m_b_ready, 0);
    endtask

    // One clock: drive at edge+1, check at edge+2, advance agents/model.
    task automatic cycle();
        logic [NP-1:0] oh;
        bit in_addr, in_r, in_w, in_b, a_hs, r_hs, w_hs, b_hs;
        int gp, pick;
        gp      = mb_gp;
        in_addr = mb_busy && !mb_addr_done;
        in_r    = mb_busy && mb_addr_done && !mb_wr;
        in_w    = mb_busy && mb_addr_done && mb_wr && !mb_wdone;
        in_b    = mb_busy && mb_addr_done && mb_wr && mb_wdone;
        oh      = mb_busy ? (NP'(1) << gp) : '0;

        for (int p = 0; p < NP; p++) begin
            if (p_st[p] == 0 && p_left[p] > 0) begin
                if (p_gap[p] > 0) p_gap[p]--;
                else begin
                    if (p_force[p]) begin
                        p_addr[p] = f_addr[p]; p_len[p] = f_len[p]; p_wr[p] = f_wr[p]; p_force[p] = 1'b0;
                    end else begin
                        p_addr[p] = $urandom() & 32'hFFFF_FFF0;
                        p_len[p]  = $urandom_range(0, 5);
                        p_wr[p]   = 1'($urandom_range(0, 1));
                    end
                    p_beat[p] = 0; p_st[p] = 1; p_wait[p] = 0;
                end
            end
            s_req_valid[p]          = (p_st[p] == 1);
            s_req_write[p]          = p_wr[p];
            s_req_addr[p*32 +: 32]  = p_addr[p];
            s_req_len[p*LW +: LW]   = LW'(p_len[p]);
            if (p_st[p] == 2) begin
                s_w_valid[p]          = ($urandom_range(0, 3) != 0);
                s_w_data[p*32 +: 32]  = wdat(p_addr[p], p_beat[p]);
                s_w_last[p]           = (p_beat[p] == p_len[p]);
            end else begin
                s_w_valid[p]          = stray_en && ($urandom_range(0, 1) == 1);
                s_w_data[p*32 +: 32]  = $urandom();
                s_w_last[p]           = 1'($urandom_range(0, 1));
            end
            s_w_strb[p*4 +: 4] = 4'($urandom_range(0, 15));
            s_r_ready[p]       = (r_mode == 1) ? (rr_phase % 2 == 1) : ($urandom_range(0, 2) != 0);
        end
        rr_phase++;

        m_req_ready = in_addr ? (addr_cnt >= sl_req_delay) : 1'($urandom_range(0, 1));
        m_r_valid   = sl_rd ? ($urandom_range(0, 3) != 0) : (stray_en && $urandom_range(0, 3) == 0);
        m_r_data    = sl_rd ? rdat(sl_addr, sl_beat) : $urandom();
        m_r_last    = sl_rd ? (sl_beat == sl_len) : 1'($urandom_range(0, 1));
        m_w_ready   = ($urandom_range(0, 3) != 0);
        m_b_valid   = sl_b ? (sl_bdelay == 0) : (stray_en && $urandom_range(0, 3) == 0);

        #1;
        chk("m_req_valid", m_req_valid, in_addr);
        if (in_addr) begin
            chk("m_req_addr",  m_req_addr, p_addr[gp]);
            chk("m_req_len",   m_req_len, LW'(p_len[gp]));
            chk("m_req_write", m_req_write, p_wr[gp]);
        end
        chk("s_req_ready", s_req_ready, (in_addr && m_req_ready) ? oh : '0);
        chk("m_r_ready",   m_r_ready, in_r && s_r_ready[gp]);
        chk("s_r_valid",   s_r_valid, (in_r && m_r_valid) ? oh : '0);
        chk("m_w_valid",   m_w_valid, in_w && s_w_valid[gp]);
        if (in_w && s_w_valid[gp]) begin
            chk("m_w_data", m_w_data, s_w_data[gp*32 +: 32]);
            chk("m_w_strb", m_w_strb, s_w_strb[gp*4 +: 4]);
            chk("m_w_last", m_w_last, s_w_last[gp]);
        end
        chk("s_w_ready",   s_w_ready, (in_w && m_w_ready) ? oh : '0);
        chk("m_b_ready",   m_b_ready, in_b);
        chk("s_b_valid",   s_b_valid, (in_b && m_b_valid) ? oh : '0);

        a_hs = in_addr && m_req_ready;
        r_hs = in_r && m_r_valid && s_r_ready[gp];
        w_hs = in_w && s_w_valid[gp] && m_w_ready;
        b_hs = in_b && m_b_valid;

        if (rst) begin
            reset_agents();
        end else begin
            if (a_hs) begin
                p_st[gp] = p_wr[gp] ? 2 : 3;
                sl_addr = m_req_addr; sl_len = int'(m_req_len); sl_beat = 0;
                sl_rd = !m_req_write; sl_wr = m_req_write;
                mb_addr_done = 1'b1; mb_wr = s_req_write[gp];
                sl_req_delay = req_slow ? 5 : $urandom_range(0, 2);
            end
            addr_cnt = (in_addr && !a_hs) ? addr_cnt + 1 : 0;
            if (r_hs) begin
                chk("port_rdata", s_r_data, rdat(p_addr[gp], p_beat[gp]));
                chk("port_rlast", s_r_last, p_beat[gp] == p_len[gp]);
                p_beat[gp]++; rx_beats[gp]++; sl_beat++;
                if (m_r_last) begin
                    sl_rd = 1'b0; p_st[gp] = 0; p_left[gp]--;
                    p_gap[gp] = $urandom_range(0, gap_max[gp]);
                    mb_busy = 1'b0; mb_last = gp;
                end
            end
            if (w_hs) begin
                chk("slave_wdata", m_w_data, wdat(sl_addr, sl_beat));
                chk("slave_wlast", m_w_last, sl_beat == sl_len);
                sl_beat++; sl_wbeats++; p_beat[gp]++;
                if (s_w_last[gp]) begin
                    p_st[gp] = 3; sl_wr = 1'b0; sl_b = 1'b1;
                    sl_bdelay = $urandom_range(0, 3); mb_wdone = 1'b1;
                end
            end else if (sl_b && !b_hs && sl_bdelay > 0) begin
                sl_bdelay--;
            end
            if (b_hs) begin
                sl_b = 1'b0; p_st[gp] = 0; p_left[gp]--; b_cnt[gp]++;
                p_gap[gp] = $urandom_range(0, gap_max[gp]);
                mb_busy = 1'b0; mb_last = gp;
            end
            if (!mb_busy && !in_addr && !in_r && !in_w && !in_b) begin
                pick = rr_pick(s_req_valid, mb_last);
                if (pick >= 0) begin
                    chk("rr_wait_bound", p_wait[pick] <= NP - 1, 1);
                    for (int p = 0; p < NP; p++) if (p != pick && p_st[p] == 1) p_wait[p]++;
                    mb_busy = 1'b1; mb_gp = pick; mb_addr_done = 1'b0; mb_wdone = 1'b0;
                    glog.push_back(pick);
                end
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic run_until_idle(input string tag, input int maxc);
        int n;
        n = 0;
        while (!all_idle() && n < maxc) begin
            cycle();
            n++;
        end
        chk({tag, "_completes"}, n < maxc, 1);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        cycle();
        rst = 1'b0;
    endtask

    initial begin
        int n;
        rst = 1'b1;
        s_req_valid = '0; s_req_write = '0; s_req_addr = '0; s_req_len = '0;
        s_w_valid = '0; s_w_data = '0; s_w_strb = '0; s_w_last = '0; s_r_ready = '0;
        m_req_ready = 1'b0; m_w_ready = 1'b0; m_r_valid = 1'b0; m_r_data = '0;
        m_r_last = 1'b0; m_b_valid = 1'b0;
        r_mode = 0; rr_phase = 0; stray_en = 1'b0; req_slow = 1'b0; sl_wbeats = 0;
        sl_addr = '0; sl_len = 0; sl_bdelay = 0;
        for (int p = 0; p < NP; p++) begin
            rx_beats[p] = 0; b_cnt[p] = 0; gap_max[p] = 3; f_addr[p] = '0; f_len[p] = 0; f_wr[p] = 1'b0;
        end
        reset_agents();
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        chk_quiet("reset");

        // single read on port 0
        f_addr[0] = 32'h1000; f_len[0] = 3; f_wr[0] = 1'b0; p_force[0] = 1'b1; p_left[0] = 1;
        rx_beats[0] = 0; rx_beats[1] = 0;
        run_until_idle("t1", 300);
        chk("t1_port0_beats", rx_beats[0], 4);
        chk("t1_port1_beats", rx_beats[1], 0);

        // simultaneous requests after reset: 0, 1, then 0 again
        do_reset();
        gap_max[0] = 0; gap_max[1] = 0;
        glog.delete();
        p_left[0] = 2; p_left[1] = 1;
        run_until_idle("t2", 600);
        chk("t2_grants", glog.size(), 3);
        chk("t2_first",  glog[0], 0);
        chk("t2_second", glog[1], 1);
        chk("t2_third",  glog[2], 0);

        // write on port 1, data 0xA0..0xA3
        f_addr[1] = 32'h2000; f_len[1] = 3; f_wr[1] = 1'b1; p_force[1] = 1'b1; p_left[1] = 1;
        sl_wbeats = 0; b_cnt[1] = 0;
        run_until_idle("t3", 300);
        chk("t3_wbeats", sl_wbeats, 4);
        chk("t3_bpulses", b_cnt[1], 1);

        // backpressure: alternating read ready, slow request accept
        r_mode = 1; req_slow = 1'b1; sl_req_delay = 5;
        f_addr[0] = 32'h3000; f_len[0] = 7; f_wr[0] = 1'b0; p_force[0] = 1'b1; p_left[0] = 3;
        p_left[1] = 2; rx_beats[0] = 0;
        run_until_idle("t4", 2000);
        r_mode = 0; req_slow = 1'b0;

        // port 0 continuous, port 1 arrives late; strays on the idle channels
        stray_en = 1'b1;
        gap_max[0] = 0; p_left[0] = 6; p_gap[1] = 4; p_left[1] = 1;
        run_until_idle("t5", 3000);
        chk("t5_port1_served", p_left[1], 0);

        // reset in the middle of a read burst
        stray_en = 1'b0;
        f_addr[0] = 32'h4000; f_len[0] = 7; f_wr[0] = 1'b0; p_force[0] = 1'b1; p_left[0] = 1;
        n = 0;
        while (p_beat[0] < 2 && n < 300) begin
            cycle();
            n++;
        end
        chk("t6_reached_beat2", n < 300, 1);
        do_reset();
        chk_quiet("t6_after_rst");
        glog.delete();
        gap_max[0] = 0; gap_max[1] = 0;
        p_left[0] = 1; p_left[1] = 1;
        run_until_idle("t6", 600);
        chk("t6_first_grant", glog[0], 0);

        // random soak
        stray_en = 1'b1; gap_max[0] = 4; gap_max[1] = 4;
        p_left[0] = 10; p_left[1] = 10;
        run_until_idle("soak", 8000);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
